// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two requesters share one byte-maskable synchronous data-memory port.
//   Port 0 is the core load/store unit and port 1 is the program loader or
//   debug master. Arbitration is round-robin and only one transaction is in
//   flight at a time. The RAM read latency is fixed at READ_LATENCY cycles.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   m{0,1}_valid          request valid, held by the requester until ready
//   m{0,1}_addr/wdata     byte address and write data
//   m{0,1}_wmask          byte write mask, 4'b0000 means read
//   m{0,1}_ready          one-cycle completion pulse
//   m{0,1}_rdata          read data, meaningful while ready is high
//   mem_en                one-cycle access strobe per transaction
//   mem_addr/wdata/wmask  latched payload of the granted request
//   mem_rdata             RAM data, READ_LATENCY cycles after mem_en
//   busy                  high in every state except IDLE
//   grant_id              port that owns the current transaction
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  // The wait counter is 4 bits wide, so only latencies 1..15 are representable.
  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: READ_LATENCY %0d outside 1..15", READ_LATENCY);
  end

  localparam logic [3:0] RL_CNT = 4'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_reg;
  logic       last_grant_reg;
  logic [3:0] cnt_reg;
  logic       pick;

  // With a single requester that port wins. With both requesting, the port
  // that was not served last wins. last_grant resets to 1, so port 0 wins the
  // first tie.
  assign pick = (m0_valid && m1_valid) ? ~last_grant_reg : m1_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      cnt_reg        <= 4'd0;
      m0_ready       <= 1'b0;
      m0_rdata       <= 32'd0;
      m1_ready       <= 1'b0;
      m1_rdata       <= 32'd0;
      mem_en         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= 32'd0;
      mem_wmask      <= 4'd0;
      busy           <= 1'b0;
      grant_id       <= 1'b0;
    end else begin
      // The strobe and ready outputs are single-cycle pulses.
      mem_en   <= 1'b0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            // The payload is latched here and drives the memory port directly
            // from these registers. Later changes on the request side are
            // therefore ignored.
            grant_id  <= pick;
            mem_addr  <= pick ? m1_addr  : m0_addr;
            mem_wdata <= pick ? m1_wdata : m0_wdata;
            mem_wmask <= pick ? m1_wmask : m0_wmask;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_wmask != 4'd0) begin
            // A write completes immediately and returns zero read data.
            if (grant_id) begin
              m1_ready <= 1'b1;
              m1_rdata <= 32'd0;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= 32'd0;
            end
            state_reg <= DONE;
          end else begin
            cnt_reg   <= RL_CNT;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          // When the count reaches 1, mem_rdata is valid in this cycle. It is
          // captured straight into the granted port's output register, so
          // the data and ready become visible together in DONE.
          if (cnt_reg <= 4'd1) begin
            if (grant_id) begin
              m1_ready <= 1'b1;
              m1_rdata <= mem_rdata;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= mem_rdata;
            end
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          last_grant_reg <= grant_id;
          busy           <= 1'b0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Instance a uses READ_LATENCY=1 and instance b uses READ_LATENCY=3. Both
// instances see the same request stimulus, and each has its own small RAM
// model. The RAM model presents read data in exactly one cycle and shows a
// junk pattern in every other cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;

  logic        a_m0_ready, a_m1_ready, a_mem_en, a_busy, a_grant_id;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_wmask;
  logic        b_m0_ready, b_m1_ready, b_mem_en, b_busy, b_grant_id;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .READ_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
    .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata),
    .busy(a_busy), .grant_id(a_grant_id)
  );

  mem_port_arbiter #(.ADDR_W(32), .READ_LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .grant_id(b_grant_id)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // RAM model for instance a, with 1-cycle read latency.
  bit   [31:0] ram_a [0:63];
  logic [31:0] rd_a;
  always @(posedge clk) begin
    if (a_mem_en && a_mem_wmask != 4'h0)
      ram_a[a_mem_addr[7:2]] <= merge(ram_a[a_mem_addr[7:2]], a_mem_wdata, a_mem_wmask);
    rd_a <= (a_mem_en && a_mem_wmask == 4'h0) ? ram_a[a_mem_addr[7:2]] : 32'hA5A5A5A5;
  end
  assign a_mem_rdata = rd_a;

  // RAM model for instance b, with 3-cycle read latency.
  bit   [31:0] ram_b [0:63];
  logic [31:0] pipe_b [0:2];
  always @(posedge clk) begin
    if (b_mem_en && b_mem_wmask != 4'h0)
      ram_b[b_mem_addr[7:2]] <= merge(ram_b[b_mem_addr[7:2]], b_mem_wdata, b_mem_wmask);
    pipe_b[0] <= (b_mem_en && b_mem_wmask == 4'h0) ? ram_b[b_mem_addr[7:2]] : 32'h5A5A5A5A;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_rdata = pipe_b[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic v, input logic [31:0] ad, input logic [31:0] wd,
                        input logic [3:0] m);
    m0_valid = v; m0_addr = ad; m0_wdata = wd; m0_wmask = m;
  endtask

  task automatic set_m1(input logic v, input logic [31:0] ad, input logic [31:0] wd,
                        input logic [3:0] m);
    m1_valid = v; m1_addr = ad; m1_wdata = wd; m1_wmask = m;
  endtask

  int served;
  int last_c;
  int k0;
  int k1;

  initial begin
    reset = 1'b0;
    set_m0(1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) step();
    chk("reset_ctrl_a", {a_busy, a_grant_id, a_mem_en, a_m0_ready, a_m1_ready, a_mem_wmask}, 0);
    chk("reset_bus_a", {a_mem_addr, a_mem_wdata}, 0);
    chk("reset_rdata_a", {a_m0_rdata, a_m1_rdata}, 0);
    reset = 1'b1;
    step();

    // First tie after reset: port 0 must win, and then port 1 is served.
    set_m0(1'b1, 32'h04, 32'h11111111, 4'hF);
    set_m1(1'b1, 32'h08, 32'h22222222, 4'hF);
    step();
    chk("tie_grant", a_grant_id, 0);
    chk("tie_issue", {a_mem_en, a_mem_addr}, {1'b1, 32'h04});
    step();
    chk("tie_ready0", {a_m0_ready, a_m1_ready}, 2'b10);
    m0_valid = 1'b0;
    step();
    chk("tie_idle", {a_busy, a_m0_ready, a_m1_ready}, 0);
    step();
    chk("tie_grant1", {a_grant_id, a_mem_en, a_mem_addr}, {1'b1, 1'b1, 32'h08});
    step();
    chk("tie_ready1", {a_m0_ready, a_m1_ready}, 2'b01);
    m1_valid = 1'b0;
    step();

    // Port 0 write: the strobe appears at N+1 only and ready at N+2 only.
    set_m0(1'b1, 32'h36, 32'hDEADBEEF, 4'hF);
    step();
    chk("wr_issue", {a_mem_en, a_mem_addr, a_mem_wdata, a_mem_wmask},
        {1'b1, 32'h36, 32'hDEADBEEF, 4'hF});
    chk("wr_issue_rdy", {a_m0_ready, a_m1_ready, a_busy, a_grant_id}, 4'b0010);
    step();
    chk("wr_done", {a_mem_en, a_m0_ready, a_m1_ready}, 3'b010);
    chk("wr_rdata", a_m0_rdata, 0);
    m0_valid = 1'b0;
    step();
    chk("wr_after", {a_m0_ready, a_m1_ready, a_busy, a_mem_en}, 0);

    // Store 0x12345678 at 0x10 so that port 1 can read it back.
    set_m0(1'b1, 32'h10, 32'h12345678, 4'hF);
    step();
    step();
    chk("pre_ready", a_m0_ready, 1);
    m0_valid = 1'b0;
    step();

    // Port 1 read with READ_LATENCY=1: ready and data arrive at N+3.
    set_m1(1'b1, 32'h10, 32'h0, 4'h0);
    step();
    chk("rd_issue", {a_mem_en, a_mem_wmask, a_mem_addr, a_grant_id},
        {1'b1, 4'h0, 32'h10, 1'b1});
    step();
    chk("rd_wait", {a_mem_en, a_m0_ready, a_m1_ready}, 0);
    step();
    chk("rd_done", {a_m0_ready, a_m1_ready}, 2'b01);
    chk("rd_data", a_m1_rdata, 32'h12345678);
    m1_valid = 1'b0;
    step();

    // Both ports request continuously, four writes each. Grants must
    // alternate 0,1,0,1,... and ready pulses must come at a 3-cycle pitch.
    k0 = 0; k1 = 0; served = 0; last_c = 0;
    set_m0(1'b1, 32'h40, 32'hC0000000, 4'hF);
    set_m1(1'b1, 32'h60, 32'hD0000000, 4'hF);
    for (int c = 0; c < 60 && served < 8; c++) begin
      step();
      if (a_m0_ready || a_m1_ready) begin
        chk("rr_port", {a_m0_ready, a_m1_ready}, (served % 2 == 0) ? 2'b10 : 2'b01);
        if (served > 0) chk("rr_pitch", c - last_c, 3);
        last_c = c;
        served++;
        if (a_m0_ready) begin
          k0++;
          if (k0 == 4) m0_valid = 1'b0;
          else begin m0_addr = 32'h40 + 4 * k0; m0_wdata = 32'hC0000000 + k0; end
        end else begin
          k1++;
          if (k1 == 4) m1_valid = 1'b0;
          else begin m1_addr = 32'h60 + 4 * k1; m1_wdata = 32'hD0000000 + k1; end
        end
      end
    end
    chk("rr_count", served, 8);
    m0_valid = 1'b0; m1_valid = 1'b0;
    step();

    // Reset during WAIT aborts the read. The re-issued read then completes
    // cleanly with no stale ready pulse and no stale read data.
    set_m0(1'b1, 32'h10, 32'h0, 4'h0);
    step();
    step();
    chk("abort_wait", a_m0_ready, 0);
    reset = 1'b0;
    #1;
    chk("abort_ctrl", {a_busy, a_grant_id, a_mem_en, a_m0_ready, a_m1_ready}, 0);
    chk("abort_rdata", {a_m0_rdata, a_m1_rdata}, 0);
    m0_valid = 1'b0;
    step();
    chk("abort_hold", {a_mem_en, a_m0_ready, a_busy}, 0);
    reset = 1'b1;
    step();
    chk("abort_release", {a_mem_en, a_m0_ready, a_m1_ready, a_busy}, 0);
    set_m0(1'b1, 32'h04, 32'h0, 4'h0);
    step();
    chk("reissue_issue", {a_mem_en, a_mem_addr}, {1'b1, 32'h04});
    step();
    chk("reissue_wait", {a_m0_ready, a_m1_ready}, 0);
    step();
    chk("reissue_done", {a_m0_ready, a_m1_ready}, 2'b10);
    chk("reissue_data", a_m0_rdata, 32'h11111111);
    m0_valid = 1'b0;
    step();

    // Instance b (READ_LATENCY=3): the payload is latched at grant, and a
    // read completes at N+5.
    reset = 1'b0;
    step();
    chk("reset_ctrl_b", {b_busy, b_grant_id, b_mem_en, b_m0_ready, b_m1_ready}, 0);
    reset = 1'b1;
    step();
    set_m0(1'b1, 32'h20, 32'hAABBCCDD, 4'b0100);
    step();
    chk("latch_issue", {b_mem_en, b_mem_addr, b_mem_wdata, b_mem_wmask},
        {1'b1, 32'h20, 32'hAABBCCDD, 4'b0100});
    m0_addr = 32'h3C; m0_wmask = 4'hF; m0_wdata = 32'h0;
    step();
    chk("latch_done", {b_m0_ready, b_mem_addr, b_mem_wmask}, {1'b1, 32'h20, 4'b0100});
    m0_valid = 1'b0;
    step();
    set_m0(1'b1, 32'h20, 32'h0, 4'h0);
    step();
    chk("rl3_issue", {b_mem_en, b_mem_wmask}, {1'b1, 4'h0});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rl3_wait", b_m0_ready, 0);
    end
    step();
    chk("rl3_done", b_m0_ready, 1);
    chk("rl3_data", b_m0_rdata, 32'h00BB0000);
    m0_valid = 1'b0;
    step();
    chk("rl3_after", {b_m0_ready, b_busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
